// File: rtl/mem_access_stage.sv
// MEM pipeline stage: issues loads/stores over a req/ack data-memory port,
// stalls upstream while an access is outstanding and registers the MEM/WB outputs.
module mem_access_stage #(
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic        clock,
  input  logic        startin,
  input  logic [31:0] alu_result_input,
  input  logic [31:0] read_data_2_input,
  input  logic [4:0]  write_register_input,
  input  logic [1:0]  WB_input,
  input  logic [1:0]  MEM_input,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        stall,
  output logic        mem_error,
  output logic [31:0] read_data_output,
  output logic [31:0] alu_result_output,
  output logic [4:0]  write_register_output,
  output logic [1:0]  WB_output,
  output logic [1:0]  o_dbg_state
);

  // Memory handshake: mem_req is raised one edge after the IDLE stall cycle and
  // held, together with mem_addr/mem_we/mem_wdata, until the edge that samples
  // mem_ack=1 (or the abort edge); exactly one request is ever outstanding.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [15:0] WAIT_LAST = 16'(MAX_WAIT - 1);

  state_t      r_state;
  logic [15:0] r_wait_cnt;
  logic        r_abort;
  logic        r_mem_req;
  logic        r_mem_we;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_wdata;
  logic        r_mem_error;
  logic [31:0] r_read_data;
  logic [31:0] r_alu_result;
  logic [4:0]  r_write_reg;
  logic [1:0]  r_wb;

  logic w_mem_op;
  logic w_illegal;
  logic w_legal_op;
  logic w_stall;

  assign w_mem_op   = |MEM_input;
  assign w_illegal  = (MEM_input == 2'b11) ||
                      (w_mem_op && (alu_result_input[1:0] != 2'b00));
  assign w_legal_op = w_mem_op && !w_illegal;

  always_comb begin
    w_stall = 1'b0;
    if (r_state == S_BUSY) begin
      w_stall = 1'b1;
    end else if (r_state == S_IDLE) begin
      w_stall = w_legal_op;
    end
  end

  always_ff @(posedge clock or posedge startin) begin
    if (startin) begin
      r_state      <= S_IDLE;
      r_wait_cnt   <= 16'd0;
      r_abort      <= 1'b0;
      r_mem_req    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= 32'd0;
      r_mem_wdata  <= 32'd0;
      r_mem_error  <= 1'b0;
      r_read_data  <= 32'd0;
      r_alu_result <= 32'd0;
      r_write_reg  <= 5'd0;
      r_wb         <= 2'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_alu_result <= alu_result_input;
          r_write_reg  <= write_register_input;
          if (!w_mem_op) begin
            r_wb        <= WB_input;
            r_read_data <= 32'd0;
          end else if (w_illegal) begin
            r_mem_error <= 1'b1;
            r_wb        <= 2'd0;
            r_read_data <= 32'd0;
          end else begin
            // Bubble now; the real MEM/WB contents are loaded from DONE.
            // read_data_output is left alone so stores never touch it.
            r_wb        <= 2'd0;
            r_mem_req   <= 1'b1;
            r_mem_we    <= MEM_input[0];
            r_mem_addr  <= alu_result_input;
            r_mem_wdata <= read_data_2_input;
            r_wait_cnt  <= 16'd0;
            r_abort     <= 1'b0;
            r_state     <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (mem_ack) begin
            r_mem_req <= 1'b0;
            if (!r_mem_we) begin
              r_read_data <= mem_rdata;
            end
            r_state <= S_DONE;
          end else if (r_wait_cnt == WAIT_LAST) begin
            r_mem_req   <= 1'b0;
            r_mem_error <= 1'b1;
            r_abort     <= 1'b1;
            r_state     <= S_DONE;
          end else begin
            r_wait_cnt <= r_wait_cnt + 16'd1;
          end
        end
        S_DONE: begin
          // Upstream still holds the instruction that made the access.
          r_alu_result <= alu_result_input;
          r_write_reg  <= write_register_input;
          r_wb         <= r_abort ? 2'd0 : WB_input;
          r_abort      <= 1'b0;
          r_state      <= S_IDLE;
        end
        default: begin
          r_state   <= S_IDLE;
          r_mem_req <= 1'b0;
        end
      endcase
    end
  end

  assign mem_req               = r_mem_req;
  assign mem_we                = r_mem_we;
  assign mem_addr              = r_mem_addr;
  assign mem_wdata             = r_mem_wdata;
  assign stall                 = w_stall;
  assign mem_error             = r_mem_error;
  assign read_data_output      = r_read_data;
  assign alu_result_output     = r_alu_result;
  assign write_register_output = r_write_reg;
  assign WB_output             = r_wb;
  assign o_dbg_state           = r_state;

  a_req_only_busy: assert property (@(posedge clock) disable iff (startin)
    r_mem_req |-> (r_state == S_BUSY));

  a_req_stable: assert property (@(posedge clock) disable iff (startin)
    (r_state == S_BUSY && $past(r_state) == S_BUSY) |->
      ($stable(r_mem_addr) && $stable(r_mem_wdata) && $stable(r_mem_we)));

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: driver tasks push expected MEM/WB results
// and memory requests into queues; a monitor and a memory responder pop and compare.
module tb_mem_access_stage;

  logic        clock;
  logic        startin;
  logic [31:0] alu_result_input;
  logic [31:0] read_data_2_input;
  logic [4:0]  write_register_input;
  logic [1:0]  WB_input;
  logic [1:0]  MEM_input;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        stall;
  logic        mem_error;
  logic [31:0] read_data_output;
  logic [31:0] alu_result_output;
  logic [4:0]  write_register_output;
  logic [1:0]  WB_output;
  logic [1:0]  o_dbg_state;

  mem_access_stage #(.MAX_WAIT(4)) dut (
    .clock                 (clock),
    .startin               (startin),
    .alu_result_input      (alu_result_input),
    .read_data_2_input     (read_data_2_input),
    .write_register_input  (write_register_input),
    .WB_input              (WB_input),
    .MEM_input             (MEM_input),
    .mem_rdata             (mem_rdata),
    .mem_ack               (mem_ack),
    .mem_req               (mem_req),
    .mem_we                (mem_we),
    .mem_addr              (mem_addr),
    .mem_wdata             (mem_wdata),
    .stall                 (stall),
    .mem_error             (mem_error),
    .read_data_output      (read_data_output),
    .alu_result_output     (alu_result_output),
    .write_register_output (write_register_output),
    .WB_output             (WB_output),
    .o_dbg_state           (o_dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- scoreboard state ----------------
  // exp_q entry: {WB(2), wreg(5), alu(32), rdata(32), err(1)}
  logic [71:0] exp_q[$];
  // req_q entry: {addr(32), we(1), wdata(32)}
  logic [64:0] req_q[$];
  int          n_vec = 0;
  int          n_err = 0;
  bit          drv_valid = 1'b0;
  bit          take = 1'b0;
  int          ack_delay = 0;
  int          exp_req_len = 0;
  logic [31:0] rdata_val = 32'd0;
  int          req_cyc = 0;
  logic [64:0] cur_req = '0;

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clock) begin
    logic [71:0] e;
    if (take) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_result: WB %0h with empty queue", WB_output);
      end else begin
        e = exp_q.pop_front();
        chk("wb_output",  {70'd0, WB_output},             {70'd0, e[71:70]});
        chk("write_reg",  {67'd0, write_register_output}, {67'd0, e[69:65]});
        chk("alu_result", {40'd0, alu_result_output},     {40'd0, e[64:33]});
        chk("read_data",  {40'd0, read_data_output},      {40'd0, e[32:1]});
        chk("mem_error",  {71'd0, mem_error},             {71'd0, e[0]});
      end
    end
    take = drv_valid && !stall && !startin;
  end

  // ---------------- memory responder ----------------
  always @(negedge clock) begin
    mem_ack   = 1'b0;
    mem_rdata = $urandom;
    if (mem_req === 1'b1) begin
      if (req_cyc == 0) begin
        if (req_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_request: addr %0h we %0b, none expected", mem_addr, mem_we);
          cur_req = {mem_addr, mem_we, mem_wdata};
        end else begin
          cur_req = req_q.pop_front();
          chk("req_fields", {7'd0, mem_addr, mem_we, mem_wdata}, {7'd0, cur_req});
        end
      end else begin
        chk("req_stable", {7'd0, mem_addr, mem_we, mem_wdata}, {7'd0, cur_req});
      end
      req_cyc++;
      if (ack_delay != 0 && req_cyc == ack_delay) begin
        mem_ack   = 1'b1;
        mem_rdata = rdata_val;
      end
    end else if (req_cyc != 0) begin
      chk("req_length", 72'(req_cyc), 72'(exp_req_len));
      req_cyc = 0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_idle();
    MEM_input            = 2'b00;
    WB_input             = 2'b00;
    alu_result_input     = 32'd0;
    read_data_2_input    = 32'd0;
    write_register_input = 5'd0;
  endtask

  // Presents one instruction until the stage lets it advance.
  task automatic issue(input logic [1:0] mem, input logic [1:0] wb, input logic [31:0] alu,
                       input logic [31:0] rd2, input logic [4:0] wr, input int ackd,
                       input logic [31:0] rdv, input int exp_stall, input logic [1:0] exp_wb,
                       input logic [31:0] exp_rd, input logic exp_err);
    int n_stall;
    bit done;
    MEM_input            = mem;
    WB_input             = wb;
    alu_result_input     = alu;
    read_data_2_input    = rd2;
    write_register_input = wr;
    ack_delay            = ackd;
    rdata_val            = rdv;
    if (exp_stall > 0) begin
      req_q.push_back({alu, mem[0], rd2});
      exp_req_len = exp_stall - 1;
    end
    exp_q.push_back({exp_wb, wr, alu, exp_rd, exp_err});
    drv_valid = 1'b1;
    n_stall = 0;
    done = 1'b0;
    for (int c = 0; c < 64 && !done; c++) begin
      @(negedge clock);
      if (stall) n_stall++;
      else done = 1'b1;
    end
    chk("stall_released", {71'd0, done}, 72'd1);
    chk("stall_cycles", 72'(n_stall), 72'(exp_stall));
    @(posedge clock);
    #1;
    drv_valid = 1'b0;
    set_idle();
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_mem_req"},   {71'd0, mem_req},               72'd0);
    chk({tag, "_mem_we"},    {71'd0, mem_we},                72'd0);
    chk({tag, "_mem_addr"},  {40'd0, mem_addr},              72'd0);
    chk({tag, "_mem_wdata"}, {40'd0, mem_wdata},             72'd0);
    chk({tag, "_mem_error"}, {71'd0, mem_error},             72'd0);
    chk({tag, "_read_data"}, {40'd0, read_data_output},      72'd0);
    chk({tag, "_alu"},       {40'd0, alu_result_output},     72'd0);
    chk({tag, "_wreg"},      {67'd0, write_register_output}, 72'd0);
    chk({tag, "_wb"},        {70'd0, WB_output},             72'd0);
    chk({tag, "_state"},     {70'd0, o_dbg_state},           72'd0);
    chk({tag, "_stall"},     {71'd0, stall},                 72'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    startin = 1'b1;
    mem_ack = 1'b0;
    mem_rdata = 32'd0;
    set_idle();
    repeat (3) @(negedge clock);
    check_outputs_zero("reset");
    #1 startin = 1'b0;
    @(posedge clock);
    #1;

    // ALU op, then load with ack on 3rd BUSY cycle, back-to-back store
    issue(2'b00, 2'b10, 32'h0000_1234, 32'h0, 5'd5, 0, 32'h0, 0, 2'b10, 32'h0, 1'b0);
    issue(2'b10, 2'b11, 32'h0000_0100, 32'h1111_1111, 5'd7, 3, 32'hDEAD_BEEF, 4,
          2'b11, 32'hDEAD_BEEF, 1'b0);
    issue(2'b01, 2'b00, 32'h0000_0008, 32'hA5A5_A5A5, 5'd0, 1, 32'h5555_5555, 2,
          2'b00, 32'hDEAD_BEEF, 1'b0);
    // timeout: MAX_WAIT=4, never acked
    issue(2'b10, 2'b11, 32'h0000_0040, 32'h0, 5'd9, 0, 32'h0, 5, 2'b00, 32'hDEAD_BEEF, 1'b1);
    // MemRead+MemWrite together is illegal
    issue(2'b11, 2'b10, 32'h0000_0020, 32'h0, 5'd3, 0, 32'h0, 0, 2'b00, 32'h0, 1'b1);
    repeat (2) @(posedge clock);
    #1;

    // reset during BUSY, then a stale ack
    MEM_input            = 2'b10;
    WB_input             = 2'b11;
    alu_result_input     = 32'h0000_0200;
    read_data_2_input    = 32'h0;
    write_register_input = 5'd6;
    ack_delay            = 0;
    req_q.push_back({32'h0000_0200, 1'b0, 32'h0});
    exp_req_len = 2;
    repeat (3) @(negedge clock);
    chk("busy_before_reset", {70'd0, o_dbg_state}, 72'd1);
    #1 startin = 1'b1;
    set_idle();
    #1;
    check_outputs_zero("rst_busy");
    @(negedge clock);
    #1 startin = 1'b0;
    #2 mem_ack = 1'b1;
    @(posedge clock);
    #1 mem_ack = 1'b0;
    @(negedge clock);
    chk("stale_ack_req",   {71'd0, mem_req},     72'd0);
    chk("stale_ack_state", {70'd0, o_dbg_state}, 72'd0);
    chk("stale_ack_rdata", {40'd0, read_data_output}, 72'd0);
    @(posedge clock);
    #1;

    issue(2'b00, 2'b10, 32'h0000_CAFE, 32'h0, 5'd31, 0, 32'h0, 0, 2'b10, 32'h0, 1'b0);
    // misaligned load
    issue(2'b10, 2'b11, 32'h0000_0102, 32'h0, 5'd4, 0, 32'h0, 0, 2'b00, 32'h0, 1'b1);
    issue(2'b10, 2'b11, 32'h0000_0004, 32'h0, 5'd12, 1, 32'h1234_5678, 2,
          2'b11, 32'h1234_5678, 1'b1);
    issue(2'b01, 2'b00, 32'h0000_000C, 32'h0F0F_0F0F, 5'd0, 2, 32'hFFFF_FFFF, 3,
          2'b00, 32'h1234_5678, 1'b1);

    repeat (4) @(negedge clock);
    chk("exp_q_drained", 72'(exp_q.size()), 72'd0);
    chk("req_q_drained", 72'(req_q.size()), 72'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

MEM stage of the five-stage pipeline, consuming the EX/MEM pipeline register outputs. It performs load/store through a request/acknowledge data-memory port and stalls the upstream pipeline while an access is outstanding. It also registers the MEM/WB outputs for write-back. Non-memory instructions pass through in one cycle.

## Interface

- MAX_WAIT, 255: maximum BUSY cycles waiting for mem_ack before abort (1..65535)

- clock  in  1  rising-edge clock
- startin  in  1  asynchronous active-high reset
- alu_result_input  in  32  address for loads/stores, result for ALU ops
- read_data_2_input  in  32  store data
- write_register_input  in  5  destination register
- WB_input  in  2  [1]=RegWrite, [0]=MemtoReg
- MEM_input  in  2  [1]=MemRead, [0]=MemWrite
- mem_rdata  in  32  load data, valid when mem_ack=1
- mem_ack  in  1  memory completion strobe
- mem_req  out  1  access request, registered
- mem_we  out  1  1=write, registered
- mem_addr  out  32  registered byte address
- mem_wdata  out  32  registered store data
- stall  out  1  combinational; upstream holds EX/MEM and earlier stages while high
- mem_error  out  1  sticky error flag, cleared only by startin
- read_data_output  out  32  MEM/WB load data
- alu_result_output  out  32  MEM/WB ALU result
- write_register_output  out  5  MEM/WB destination
- WB_output  out  2  MEM/WB control

## Operation

- Reset (startin=1, asynchronous): state=IDLE, wait counter=0, and every output register is 0. This covers mem_req, mem_we, mem_addr, mem_wdata, mem_error, read_data_output, alu_result_output, write_register_output and WB_output. stall is combinational, so it reads 0 while in IDLE with MEM_input=0.
- Memory op: MEM_input != 0. Illegal op is either of:
  - MEM_input=2'b11
  - memory op with alu_result_input[1:0] != 0
- FSM states: IDLE, BUSY, DONE.
- IDLE, MEM_input=0:
  - stall=0
  - each edge loads MEM/WB from the inputs; read_data_output <= 0
- IDLE, illegal op:
  - stall=0, no request issued
  - mem_error <= 1
  - MEM/WB loads a bubble (WB_output <= 0, other fields loaded normally)
- IDLE, legal memory op:
  - stall=1
  - next edge: mem_req<=1; mem_we<=MEM_input[0]; mem_addr<=alu_result_input; mem_wdata<=read_data_2_input; counter<=0; state->BUSY
  - MEM/WB loads a bubble (WB_output <= 0)
- BUSY:
  - stall=1
  - MEM/WB holds its contents
  - mem_req and mem_addr/mem_wdata/mem_we stay stable until completion
  - edge with mem_ack=1: mem_req<=0; on a read, read_data_output<=mem_rdata; state->DONE
  - edge with mem_ack=0 and counter=MAX_WAIT-1: mem_req<=0; mem_error<=1; abort flag set; state->DONE
  - otherwise counter increments
- DONE:
  - stall=0
  - next edge loads alu_result_output, write_register_output and WB_output from the inputs, which are still the held instruction
  - aborted access: WB_output <= 0 instead
  - state->IDLE
  - the upstream advances on the same edge
- mem_ack is ignored outside BUSY.
- Stores never modify read_data_output.

## Timing

- Non-memory op: 1 cycle, zero stall.
- Memory op with ack sampled on the first BUSY edge: 3 cycles (IDLE-stall, BUSY, DONE), 2 stall cycles.
- Each extra ack wait cycle adds 1.
- Abort: MAX_WAIT BUSY cycles, then DONE.
- mem_req rises exactly one edge after the IDLE stall cycle and falls on the ack or abort edge. It is never high in IDLE or DONE.
- Back-to-back memory ops: DONE→IDLE, then the next op stalls in IDLE. No overlap, at most one outstanding request.
- startin during BUSY:
  - mem_req drops immediately, state=IDLE
  - a later mem_ack for the abandoned access is ignored

## Test plan

- ALU op: WB_input=2'b10, alu_result_input=0x0000_1234, write_register_input=5 → next edge WB_output=2'b10, alu_result_output=0x1234, write_register_output=5, stall never high.
- Load with ack on the 3rd BUSY cycle:
  - stimulus: MEM_input=2'b10, addr 0x100, mem_rdata=0xDEAD_BEEF
  - mem_req high for 3 cycles with mem_addr=0x100, mem_we=0
  - stall high for 4 cycles
  - after DONE: read_data_output=0xDEADBEEF, WB_output=2'b11
- Store: MEM_input=2'b01, addr 0x8, data 0xA5A5_A5A5, ack on first BUSY edge → mem_we=1, mem_wdata=0xA5A5A5A5, stall high 2 cycles, read_data_output unchanged.
- Misaligned load at addr 0x102 → mem_req stays 0, mem_error=1, WB_output=0, stall=0.
- Timeout with MAX_WAIT=4 and no ack → mem_req high exactly 4 cycles, then 0; mem_error=1; WB_output=0 after DONE.
- Reset during BUSY, then ack pulse → all outputs 0, state IDLE, ack ignored, next ALU op flows normally.
